pll_lock_supervisor: RTL and testbench
======================================

Name: pll_lock_supervisor

Overview:
- Sequences the iCE40 PLL from the 12 MHz reference-clock domain.
- Pulses the PLL's RESETB at start-up and watches the PLL LOCK output.
- Qualifies lock as stable, then releases `ready` for the downstream reset tree.
- On lock timeout or lock loss: retries a bounded number of times, then declares failure. With the optional fallback it also switches the PLL to bypass.

Parameters:
- RESET_CYCLES, 16: cycles `pll_resetb` is held low per attempt (>=1).
- LOCK_TIMEOUT, 12000: cycles to wait for synchronised lock before a retry (1 ms at 12 MHz).
- STABLE_CYCLES, 1024: consecutive locked cycles required before `ready`.
- LOSS_CYCLES, 4: consecutive unlocked cycles in RUN treated as real lock loss; shorter dropouts are filtered.
- MAX_RETRIES, 3: failed attempts tolerated before FAILED (1..7).

Ports:
- clock_in  input  1  12 MHz reference clock, free-running.
- reset_n  input  1  asynchronous active-low reset.
- pll_locked  input  1  PLL LOCK; asynchronous to clock_in.
- restart  input  1  single-cycle request to re-run the full sequence.
- restart_ack  output  1  one-cycle pulse when a restart is accepted.
- pll_resetb  output  1  to PLL RESETB; low = PLL held in reset.
- pll_bypass  output  1  to PLL BYPASS.
- ready  output  1  clock qualified; downstream may leave reset.
- failed  output  1  retries exhausted.
- retry_count  output  3  failed attempts since last reset/restart.
- loss_count  output  8  lock-loss events in RUN; saturates at 255.
- state  output  3  current FSM state encoding, for debug.

Behaviour:
- Reset (reset_n low, asynchronous): state=RESET_PLL, all counters 0.
  - Outputs: pll_resetb=0, pll_bypass=0, ready=0, failed=0, restart_ack=0, retry_count=0, loss_count=0.
- pll_locked passes through a 2-flop synchroniser; `lk` denotes its output. Lock observation latency is 2 cycles.
- One cycle counter, cleared on every state transition.
- RESET_PLL:
  - pll_resetb=0.
  - After RESET_CYCLES cycles go to WAIT_LOCK; pll_resetb=1 from that cycle.
- WAIT_LOCK:
  - lk=1: go to STABLE.
  - Counter reaches LOCK_TIMEOUT-1 with lk=0: retry_count+1.
    - If the new value is >= MAX_RETRIES, go to FAILED.
    - Otherwise go to RESET_PLL.
- STABLE:
  - Any lk=0 cycle: go back to WAIT_LOCK with the counter cleared. This is not a retry; the timeout restarts.
  - STABLE_CYCLES consecutive lk=1 cycles: go to RUN.
- RUN:
  - ready=1, registered and asserted on the first RUN cycle.
  - The unlocked-run counter increments while lk=0 and clears when lk=1.
  - When it reaches LOSS_CYCLES: ready=0 on the next cycle, loss_count+1 (saturating), go to RESET_PLL.
  - retry_count clears on entry to RUN.
- FAILED:
  - failed=1 and pll_resetb=1.
  - Behaviour otherwise depends on PLL_BYPASS_FALLBACK_EN (see Optional Feature).
- restart:
  - Accepted in any state.
  - Next cycle: restart_ack=1, go to RESET_PLL, ready=0, failed=0, pll_bypass=0, retry_count=0.
  - loss_count is kept.
- Simultaneous events: restart has priority over any timeout, loss or lock event in the same cycle.
- Reset mid-sequence: asynchronous return to the reset values; no partial counts survive.
- Counter widths are $clog2 of the largest of RESET_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES, plus 1. No wrap is possible before the terminal compare.

Optional Feature:
- Macro: PLL_BYPASS_FALLBACK_EN.
- Defined: FAILED drives pll_bypass=1 and ready=1, so the system runs from the 12 MHz reference passed through the PLL. failed=1 stays set. Lock loss is ignored in FAILED.
- Not defined: pll_bypass is tied 0. FAILED holds ready=0 until restart or reset.

Decomposition:
- Package pll_sup_pkg holds:
  - State encoding: RESET_PLL=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAILED=4.
  - Width constants for retry_count and loss_count.
- Sub-module sync2: a generic 2-flop synchroniser with asynchronous active-low reset, reset value 0. It is reused later for the output-domain reset.

Test Plan:
(Parameters for all scenarios: RESET_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, LOSS_CYCLES=3, MAX_RETRIES=2.)
- Normal bring-up: release reset_n, raise pll_locked at cycle 10 -> pll_resetb rises at cycle 4, ready=1 at cycle 10+2+8, retry_count=0.
- Chatter in STABLE: pll_locked drops for 1 cycle mid-qualification -> FSM returns to WAIT_LOCK, ready stays 0, retry_count unchanged, ready rises 8 cycles after lock returns.
- Glitch filtering in RUN: 2-cycle dropout -> ready stays 1, loss_count=0. 3-cycle dropout -> ready falls, loss_count=1, pll_resetb low for 4 cycles.
- Timeout and fail: pll_locked held 0 -> two RESET_PLL/WAIT_LOCK rounds, then failed=1 and retry_count=2. Without the macro: ready=0, pll_bypass=0. With PLL_BYPASS_FALLBACK_EN: pll_bypass=1, ready=1.
- Restart from FAILED: pulse restart in the same cycle as a WAIT_LOCK timeout -> restart_ack=1 next cycle, failed=0, retry_count=0, state=RESET_PLL.
- Asynchronous reset in RUN: assert reset_n low mid-cycle -> ready=0 and pll_resetb=0 immediately; loss_count=0 after release.

Source files
------------

// File: rtl/pll_lock_supervisor_pkg.sv
// -----------------------------------------------------------------------------
// pll_sup_pkg
// Shared definitions for the PLL lock supervisor:
//   - state_t   : FSM state encoding (also exported on the debug `state` port)
//   - STATE_W   : width of the state encoding
//   - RETRY_W   : width of retry_count
//   - LOSS_W    : width of loss_count
//   - max3()    : helper used to size the shared cycle counter
// -----------------------------------------------------------------------------
package pll_sup_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned RETRY_W = 3;
  localparam int unsigned LOSS_W  = 8;

  typedef enum logic [STATE_W-1:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAILED    = 3'd4
  } state_t;

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pll_lock_supervisor_sync2.sv
// -----------------------------------------------------------------------------
// sync2
// Generic two-flop synchroniser for a single asynchronous level signal.
// Reset value is 0. Also intended for the output-domain reset release.
//
// Ports:
//   clk    in  1  destination-domain clock
//   rst_n  in  1  asynchronous active-low reset
//   d      in  1  asynchronous input
//   q      out 1  synchronised output (2 cycles of latency)
// -----------------------------------------------------------------------------
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: non-blocking assignments make both flops sample the pre-edge values,
  // giving a real two-stage pipeline instead of a single flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_supervisor.sv
// -----------------------------------------------------------------------------
// pll_lock_supervisor
// Brings up the iCE40 PLL from the 12 MHz reference domain: pulses RESETB,
// waits for LOCK, qualifies it as stable, then raises `ready` for the
// downstream reset tree. Lock timeouts and lock losses trigger bounded
// retries; once retries are exhausted the block parks in FAILED.
//
// Build option:
//   PLL_BYPASS_FALLBACK_EN  when defined, FAILED switches the PLL to bypass
//                           and raises `ready` so the system runs from the
//                           reference clock; otherwise pll_bypass stays 0.
//
// Ports:
//   clock_in     in  1  12 MHz reference clock
//   reset_n      in  1  asynchronous active-low reset
//   pll_locked   in  1  PLL LOCK, asynchronous to clock_in
//   restart      in  1  single-cycle request to re-run the whole sequence
//   restart_ack  out 1  one-cycle pulse when a restart is accepted
//   pll_resetb   out 1  PLL RESETB (low = PLL held in reset)
//   pll_bypass   out 1  PLL BYPASS
//   ready        out 1  clock qualified
//   failed       out 1  retries exhausted
//   retry_count  out 3  failed attempts since last reset/restart
//   loss_count   out 8  lock-loss events in RUN, saturating
//   state        out 3  FSM state (debug)
// -----------------------------------------------------------------------------
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int unsigned RESET_CYCLES  = 16,     // >= 1
  parameter int unsigned LOCK_TIMEOUT  = 12000,  // >= 1
  parameter int unsigned STABLE_CYCLES = 1024,   // >= 2
  parameter int unsigned LOSS_CYCLES   = 4,      // >= 1, must fit the counter
  parameter int unsigned MAX_RETRIES   = 3       // 1..7
) (
  input  logic               clock_in,
  input  logic               reset_n,
  input  logic               pll_locked,
  input  logic               restart,
  output logic               restart_ack,
  output logic               pll_resetb,
  output logic               pll_bypass,
  output logic               ready,
  output logic               failed,
  output logic [RETRY_W-1:0] retry_count,
  output logic [LOSS_W-1:0]  loss_count,
  output logic [STATE_W-1:0] state
);

`ifdef PLL_BYPASS_FALLBACK_EN
  localparam bit FALLBACK_EN = 1'b1;
`else
  localparam bit FALLBACK_EN = 1'b0;
`endif

  localparam int unsigned CNT_W = $clog2(max3(RESET_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)) + 1;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t RESET_LAST   = cnt_t'(RESET_CYCLES - 1);
  localparam cnt_t TIMEOUT_LAST = cnt_t'(LOCK_TIMEOUT - 1);
  // The WAIT_LOCK cycle that first sees lock is the first of the
  // STABLE_CYCLES consecutive locked cycles, so STABLE itself runs one less.
  localparam cnt_t STABLE_LAST  = cnt_t'(STABLE_CYCLES - 2);
  localparam cnt_t LOSS_LAST    = cnt_t'(LOSS_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRIES);

  logic               lk;
  state_t             state_q;
  cnt_t               cnt;
  logic [RETRY_W-1:0] retry_next;

  sync2 u_lock_sync (
    .clk   (clock_in),
    .rst_n (reset_n),
    .d     (pll_locked),
    .q     (lk)
  );

  assign retry_next = retry_count + RETRY_W'(1);
  assign state      = state_q;

  // Single counter shared by all states: RESET_PLL hold time, WAIT_LOCK
  // timeout, STABLE qualification and the RUN unlocked-run filter.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= RESET_PLL;
      cnt         <= '0;
      restart_ack <= 1'b0;
      pll_resetb  <= 1'b0;
      pll_bypass  <= 1'b0;
      ready       <= 1'b0;
      failed      <= 1'b0;
      retry_count <= '0;
      loss_count  <= '0;
    end else begin
      restart_ack <= 1'b0;
      // restart outranks every timeout, loss or lock event this cycle.
      if (restart) begin
        state_q     <= RESET_PLL;
        cnt         <= '0;
        restart_ack <= 1'b1;
        pll_resetb  <= 1'b0;
        pll_bypass  <= 1'b0;
        ready       <= 1'b0;
        failed      <= 1'b0;
        retry_count <= '0;
      end else begin
        unique case (state_q)
          RESET_PLL: begin
            if (cnt == RESET_LAST) begin
              state_q    <= WAIT_LOCK;
              cnt        <= '0;
              pll_resetb <= 1'b1;
            end else begin
              cnt <= cnt + cnt_t'(1);
            end
          end

          WAIT_LOCK: begin
            if (lk) begin
              state_q <= STABLE;
              cnt     <= '0;
            end else if (cnt == TIMEOUT_LAST) begin
              cnt         <= '0;
              retry_count <= retry_next;
              if (retry_next >= RETRY_LIMIT) begin
                state_q    <= FAILED;
                failed     <= 1'b1;
                pll_bypass <= FALLBACK_EN;
                ready      <= FALLBACK_EN;
              end else begin
                state_q    <= RESET_PLL;
                pll_resetb <= 1'b0;
              end
            end else begin
              cnt <= cnt + cnt_t'(1);
            end
          end

          STABLE: begin
            // A single unlocked cycle restarts qualification and the lock
            // timeout, but does not consume a retry.
            if (!lk) begin
              state_q <= WAIT_LOCK;
              cnt     <= '0;
            end else if (cnt == STABLE_LAST) begin
              state_q     <= RUN;
              cnt         <= '0;
              ready       <= 1'b1;
              retry_count <= '0;
            end else begin
              cnt <= cnt + cnt_t'(1);
            end
          end

          RUN: begin
            // cnt counts consecutive unlocked cycles; short dropouts are
            // filtered by clearing it on any locked cycle.
            if (lk) begin
              cnt <= '0;
            end else if (cnt == LOSS_LAST) begin
              state_q    <= RESET_PLL;
              cnt        <= '0;
              ready      <= 1'b0;
              pll_resetb <= 1'b0;
              if (loss_count != '1) begin
                loss_count <= loss_count + LOSS_W'(1);
              end
            end else begin
              cnt <= cnt + cnt_t'(1);
            end
          end

          FAILED: begin
            // Parked until restart or reset; lock activity is ignored.
            cnt <= '0;
          end

          default: begin
            state_q    <= RESET_PLL;
            cnt        <= '0;
            pll_resetb <= 1'b0;
            ready      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// -----------------------------------------------------------------------------
// tb_pll_lock_supervisor
// Directed bench for pll_lock_supervisor with RESET_CYCLES=4, LOCK_TIMEOUT=20,
// STABLE_CYCLES=8, LOSS_CYCLES=3, MAX_RETRIES=2. Cycle numbers below count
// rising edges after reset_n is released; inputs change and outputs are
// sampled 1 time unit after an edge.
// -----------------------------------------------------------------------------
module tb_pll_lock_supervisor;
  import pll_sup_pkg::*;

`ifdef PLL_BYPASS_FALLBACK_EN
  localparam bit FB = 1'b1;
`else
  localparam bit FB = 1'b0;
`endif

  logic               clock_in   = 1'b0;
  logic               reset_n    = 1'b0;
  logic               pll_locked = 1'b0;
  logic               restart    = 1'b0;
  logic               restart_ack;
  logic               pll_resetb;
  logic               pll_bypass;
  logic               ready;
  logic               failed;
  logic [RETRY_W-1:0] retry_count;
  logic [LOSS_W-1:0]  loss_count;
  logic [STATE_W-1:0] state;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  pll_lock_supervisor #(
    .RESET_CYCLES  (4),
    .LOCK_TIMEOUT  (20),
    .STABLE_CYCLES (8),
    .LOSS_CYCLES   (3),
    .MAX_RETRIES   (2)
  ) dut (
    .clock_in    (clock_in),
    .reset_n     (reset_n),
    .pll_locked  (pll_locked),
    .restart     (restart),
    .restart_ack (restart_ack),
    .pll_resetb  (pll_resetb),
    .pll_bypass  (pll_bypass),
    .ready       (ready),
    .failed      (failed),
    .retry_count (retry_count),
    .loss_count  (loss_count),
    .state       (state)
  );

  initial forever #5 clock_in = ~clock_in;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock_in);
      #1;
      cyc++;
    end
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic do_reset();
    reset_n    = 1'b0;
    pll_locked = 1'b0;
    restart    = 1'b0;
    tick(2);
    reset_n = 1'b1;
    cyc     = 0;
  endtask

  // Reset value of every output, with pll_locked high to show reset dominates.
  task automatic test_reset();
    reset_n    = 1'b0;
    pll_locked = 1'b1;
    tick(3);
    n_cmp++; if (state !== RESET_PLL) begin n_fail++; $display("FAIL reset_state: got %0d want 0", state); end
    n_cmp++; if (pll_resetb !== 1'b0) begin n_fail++; $display("FAIL reset_pll_resetb: got %b want 0", pll_resetb); end
    n_cmp++; if (pll_bypass !== 1'b0) begin n_fail++; $display("FAIL reset_pll_bypass: got %b want 0", pll_bypass); end
    n_cmp++; if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", ready); end
    n_cmp++; if (failed !== 1'b0) begin n_fail++; $display("FAIL reset_failed: got %b want 0", failed); end
    n_cmp++; if (restart_ack !== 1'b0) begin n_fail++; $display("FAIL reset_restart_ack: got %b want 0", restart_ack); end
    n_cmp++; if (retry_count !== 3'd0) begin n_fail++; $display("FAIL reset_retry_count: got %0d want 0", retry_count); end
    n_cmp++; if (loss_count !== 8'd0) begin n_fail++; $display("FAIL reset_loss_count: got %0d want 0", loss_count); end
    pll_locked = 1'b0;
  endtask

  // Lock raised after edge 10: lk high from cycle 12, ready at 10+2+8 = 20.
  task automatic test_bring_up();
    do_reset();
    run_to(3);
    n_cmp++; if (pll_resetb !== 1'b0) begin n_fail++; $display("FAIL bringup_resetb_c3: got %b want 0", pll_resetb); end
    run_to(4);
    n_cmp++; if (pll_resetb !== 1'b1) begin n_fail++; $display("FAIL bringup_resetb_c4: got %b want 1", pll_resetb); end
    n_cmp++; if (state !== WAIT_LOCK) begin n_fail++; $display("FAIL bringup_state_c4: got %0d want 1", state); end
    run_to(10);
    pll_locked = 1'b1;
    run_to(12);
    n_cmp++; if (state !== WAIT_LOCK) begin n_fail++; $display("FAIL bringup_state_c12: got %0d want 1", state); end
    run_to(13);
    n_cmp++; if (state !== STABLE) begin n_fail++; $display("FAIL bringup_state_c13: got %0d want 2", state); end
    run_to(19);
    n_cmp++; if (ready !== 1'b0) begin n_fail++; $display("FAIL bringup_ready_c19: got %b want 0", ready); end
    run_to(20);
    n_cmp++; if (ready !== 1'b1) begin n_fail++; $display("FAIL bringup_ready_c20: got %b want 1", ready); end
    n_cmp++; if (state !== RUN) begin n_fail++; $display("FAIL bringup_state_c20: got %0d want 3", state); end
    n_cmp++; if (retry_count !== 3'd0) begin n_fail++; $display("FAIL bringup_retry: got %0d want 0", retry_count); end
    n_cmp++; if (failed !== 1'b0) begin n_fail++; $display("FAIL bringup_failed: got %b want 0", failed); end
  endtask

  // One-cycle dropout (low after edge 15, back after 16) during STABLE.
  task automatic test_stable_chatter();
    do_reset();
    run_to(10);
    pll_locked = 1'b1;
    run_to(15);
    pll_locked = 1'b0;
    run_to(16);
    pll_locked = 1'b1;
    run_to(17);
    n_cmp++; if (state !== STABLE) begin n_fail++; $display("FAIL chatter_state_c17: got %0d want 2", state); end
    run_to(18);
    n_cmp++; if (state !== WAIT_LOCK) begin n_fail++; $display("FAIL chatter_state_c18: got %0d want 1", state); end
    n_cmp++; if (retry_count !== 3'd0) begin n_fail++; $display("FAIL chatter_retry: got %0d want 0", retry_count); end
    n_cmp++; if (pll_resetb !== 1'b1) begin n_fail++; $display("FAIL chatter_resetb: got %b want 1", pll_resetb); end
    run_to(25);
    n_cmp++; if (ready !== 1'b0) begin n_fail++; $display("FAIL chatter_ready_c25: got %b want 0", ready); end
    run_to(26);
    n_cmp++; if (ready !== 1'b1) begin n_fail++; $display("FAIL chatter_ready_c26: got %b want 1", ready); end
  endtask

  // RUN from cycle 20; 2-cycle dropout is filtered, 3-cycle dropout is a loss.
  task automatic test_run_glitch();
    do_reset();
    run_to(10);
    pll_locked = 1'b1;
    run_to(24);
    pll_locked = 1'b0;
    run_to(26);
    pll_locked = 1'b1;
    run_to(30);
    n_cmp++; if (ready !== 1'b1) begin n_fail++; $display("FAIL glitch2_ready: got %b want 1", ready); end
    n_cmp++; if (loss_count !== 8'd0) begin n_fail++; $display("FAIL glitch2_loss: got %0d want 0", loss_count); end
    n_cmp++; if (state !== RUN) begin n_fail++; $display("FAIL glitch2_state: got %0d want 3", state); end
    run_to(34);
    pll_locked = 1'b0;
    run_to(37);
    pll_locked = 1'b1;
    run_to(38);
    n_cmp++; if (ready !== 1'b1) begin n_fail++; $display("FAIL glitch3_ready_c38: got %b want 1", ready); end
    run_to(39);
    n_cmp++; if (ready !== 1'b0) begin n_fail++; $display("FAIL glitch3_ready_c39: got %b want 0", ready); end
    n_cmp++; if (loss_count !== 8'd1) begin n_fail++; $display("FAIL glitch3_loss: got %0d want 1", loss_count); end
    n_cmp++; if (state !== RESET_PLL) begin n_fail++; $display("FAIL glitch3_state: got %0d want 0", state); end
    n_cmp++; if (pll_resetb !== 1'b0) begin n_fail++; $display("FAIL glitch3_resetb_c39: got %b want 0", pll_resetb); end
    run_to(42);
    n_cmp++; if (pll_resetb !== 1'b0) begin n_fail++; $display("FAIL glitch3_resetb_c42: got %b want 0", pll_resetb); end
    run_to(43);
    n_cmp++; if (pll_resetb !== 1'b1) begin n_fail++; $display("FAIL glitch3_resetb_c43: got %b want 1", pll_resetb); end
    run_to(50);
    n_cmp++; if (ready !== 1'b0) begin n_fail++; $display("FAIL relock_ready_c50: got %b want 0", ready); end
    run_to(51);
    n_cmp++; if (ready !== 1'b1) begin n_fail++; $display("FAIL relock_ready_c51: got %b want 1", ready); end
    // restart from RUN keeps loss_count.
    run_to(53);
    restart = 1'b1;
    run_to(54);
    restart = 1'b0;
    n_cmp++; if (restart_ack !== 1'b1) begin n_fail++; $display("FAIL run_restart_ack: got %b want 1", restart_ack); end
    n_cmp++; if (ready !== 1'b0) begin n_fail++; $display("FAIL run_restart_ready: got %b want 0", ready); end
    n_cmp++; if (loss_count !== 8'd1) begin n_fail++; $display("FAIL run_restart_loss: got %0d want 1", loss_count); end
  endtask

  // No lock: timeouts at 24 and 48, FAILED from 48; then restart from FAILED.
  task automatic test_timeout_fail();
    do_reset();
    run_to(23);
    n_cmp++; if (state !== WAIT_LOCK) begin n_fail++; $display("FAIL timeout_state_c23: got %0d want 1", state); end
    run_to(24);
    n_cmp++; if (state !== RESET_PLL) begin n_fail++; $display("FAIL timeout_state_c24: got %0d want 0", state); end
    n_cmp++; if (retry_count !== 3'd1) begin n_fail++; $display("FAIL timeout_retry_c24: got %0d want 1", retry_count); end
    n_cmp++; if (pll_resetb !== 1'b0) begin n_fail++; $display("FAIL timeout_resetb_c24: got %b want 0", pll_resetb); end
    run_to(28);
    n_cmp++; if (state !== WAIT_LOCK) begin n_fail++; $display("FAIL timeout_state_c28: got %0d want 1", state); end
    run_to(47);
    n_cmp++; if (failed !== 1'b0) begin n_fail++; $display("FAIL timeout_failed_c47: got %b want 0", failed); end
    run_to(48);
    n_cmp++; if (state !== FAILED) begin n_fail++; $display("FAIL fail_state: got %0d want 4", state); end
    n_cmp++; if (failed !== 1'b1) begin n_fail++; $display("FAIL fail_failed: got %b want 1", failed); end
    n_cmp++; if (retry_count !== 3'd2) begin n_fail++; $display("FAIL fail_retry: got %0d want 2", retry_count); end
    n_cmp++; if (pll_resetb !== 1'b1) begin n_fail++; $display("FAIL fail_resetb: got %b want 1", pll_resetb); end
    n_cmp++; if (pll_bypass !== FB) begin n_fail++; $display("FAIL fail_bypass: got %b want %b", pll_bypass, FB); end
    n_cmp++; if (ready !== FB) begin n_fail++; $display("FAIL fail_ready: got %b want %b", ready, FB); end
    run_to(60);
    n_cmp++; if (state !== FAILED) begin n_fail++; $display("FAIL fail_hold_state: got %0d want 4", state); end
    restart = 1'b1;
    run_to(61);
    restart = 1'b0;
    n_cmp++; if (restart_ack !== 1'b1) begin n_fail++; $display("FAIL fail_restart_ack: got %b want 1", restart_ack); end
    n_cmp++; if (failed !== 1'b0) begin n_fail++; $display("FAIL fail_restart_failed: got %b want 0", failed); end
    n_cmp++; if (retry_count !== 3'd0) begin n_fail++; $display("FAIL fail_restart_retry: got %0d want 0", retry_count); end
    n_cmp++; if (pll_bypass !== 1'b0) begin n_fail++; $display("FAIL fail_restart_bypass: got %b want 0", pll_bypass); end
    n_cmp++; if (ready !== 1'b0) begin n_fail++; $display("FAIL fail_restart_ready: got %b want 0", ready); end
    n_cmp++; if (state !== RESET_PLL) begin n_fail++; $display("FAIL fail_restart_state: got %0d want 0", state); end
    run_to(62);
    n_cmp++; if (restart_ack !== 1'b0) begin n_fail++; $display("FAIL fail_restart_ack_pulse: got %b want 0", restart_ack); end
  endtask

  // restart lands on the same edge (48) as the final WAIT_LOCK timeout.
  task automatic test_restart_collision();
    do_reset();
    run_to(47);
    restart = 1'b1;
    run_to(48);
    restart = 1'b0;
    n_cmp++; if (restart_ack !== 1'b1) begin n_fail++; $display("FAIL collide_ack: got %b want 1", restart_ack); end
    n_cmp++; if (failed !== 1'b0) begin n_fail++; $display("FAIL collide_failed: got %b want 0", failed); end
    n_cmp++; if (retry_count !== 3'd0) begin n_fail++; $display("FAIL collide_retry: got %0d want 0", retry_count); end
    n_cmp++; if (state !== RESET_PLL) begin n_fail++; $display("FAIL collide_state: got %0d want 0", state); end
    n_cmp++; if (pll_resetb !== 1'b0) begin n_fail++; $display("FAIL collide_resetb: got %b want 0", pll_resetb); end
    run_to(49);
    n_cmp++; if (restart_ack !== 1'b0) begin n_fail++; $display("FAIL collide_ack_pulse: got %b want 0", restart_ack); end
    run_to(52);
    n_cmp++; if (state !== WAIT_LOCK) begin n_fail++; $display("FAIL collide_state_c52: got %0d want 1", state); end
  endtask

  // Loss at 27 gives loss_count=1, RUN again at 39, then reset mid-cycle.
  task automatic test_async_reset_run();
    do_reset();
    run_to(10);
    pll_locked = 1'b1;
    run_to(22);
    pll_locked = 1'b0;
    run_to(25);
    pll_locked = 1'b1;
    run_to(27);
    n_cmp++; if (loss_count !== 8'd1) begin n_fail++; $display("FAIL areset_loss_pre: got %0d want 1", loss_count); end
    run_to(39);
    n_cmp++; if (ready !== 1'b1) begin n_fail++; $display("FAIL areset_ready_pre: got %b want 1", ready); end
    run_to(41);
    #2;
    reset_n = 1'b0;
    #1;
    n_cmp++; if (ready !== 1'b0) begin n_fail++; $display("FAIL areset_ready_now: got %b want 0", ready); end
    n_cmp++; if (pll_resetb !== 1'b0) begin n_fail++; $display("FAIL areset_resetb_now: got %b want 0", pll_resetb); end
    n_cmp++; if (state !== RESET_PLL) begin n_fail++; $display("FAIL areset_state_now: got %0d want 0", state); end
    tick(2);
    reset_n = 1'b1;
    cyc     = 0;
    run_to(1);
    n_cmp++; if (loss_count !== 8'd0) begin n_fail++; $display("FAIL areset_loss_post: got %0d want 0", loss_count); end
    n_cmp++; if (retry_count !== 3'd0) begin n_fail++; $display("FAIL areset_retry_post: got %0d want 0", retry_count); end
    run_to(4);
    n_cmp++; if (pll_resetb !== 1'b1) begin n_fail++; $display("FAIL areset_resetb_c4: got %b want 1", pll_resetb); end
  endtask

  initial begin
    test_reset();
    test_bring_up();
    test_stable_chatter();
    test_run_glitch();
    test_timeout_fail();
    test_restart_collision();
    test_async_reset_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
